// File: rtl/game_state_ctrl.sv
// Game-flow controller: IDLE -> MENU -> PLAY -> OVER -> MENU, with a BCD play
// timer, optional pause and optional time limit. Every output is a flop.
//
// state | meaning
// IDLE  | power-up hold, leaves after IDLE_SECS seconds
// MENU  | waiting for any fresh button press, timer shows last result
// PLAY  | game running, timer counts seconds, pause toggle allowed
// OVER  | timer frozen, freeze set, returns to MENU after OVER_SECS seconds
module game_state_ctrl #(
  parameter int unsigned TICK_DIV     = 100_000_000,
  parameter int unsigned NUM_BTN      = 3,
  parameter int unsigned IDLE_SECS    = 1,
  parameter int unsigned OVER_SECS    = 2,
  parameter int unsigned TIMER_DIGITS = 3,
  parameter int unsigned PAUSE_EN     = 1,
  parameter int unsigned PAUSE_BTN    = 0,
  parameter int unsigned TIME_LIMIT   = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_BTN-1:0]        btn,
  input  logic                      game_over_evt,
  output logic [1:0]                state,
  output logic                      state_entry,
  output logic                      start_pulse,
  output logic [4*TIMER_DIGITS-1:0] timer_bcd,
  output logic                      sec_tick,
  output logic                      paused,
  output logic                      freeze
);

  localparam int unsigned PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned MAXS = (IDLE_SECS > OVER_SECS) ? IDLE_SECS : OVER_SECS;
  localparam int unsigned CW   = $clog2(MAXS + 1);
  localparam int unsigned TW   = 4 * TIMER_DIGITS;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MENU = 2'b01,
    S_PLAY = 2'b11,
    S_OVER = 2'b10
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_BTN-1:0] btn_q, rise;
  logic [PW-1:0]      presc_q, presc_d;
  logic [CW-1:0]      cnt_q, cnt_d, cnt_inc;
  logic [31:0]        secs_q, secs_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic               state_entry_q, state_entry_d;
  logic               start_pulse_q, start_pulse_d;
  logic               sec_tick_q, sec_tick_d;
  logic               paused_q, paused_d;
  logic               freeze_q, freeze_d;
  logic               wrap, entry;

  // Ripple-carry BCD increment that sticks at all nines.
  function automatic logic [TW-1:0] bcd_inc(input logic [TW-1:0] v);
    logic [TW-1:0] r;
    logic          carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < int'(TIMER_DIGITS); i++) begin
      if (carry) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return carry ? v : r;
  endfunction

  always_comb begin
    rise     = btn & ~btn_q;
    wrap     = ~paused_q & (presc_q == PW'(TICK_DIV - 1));
    presc_d  = paused_q ? presc_q : (wrap ? '0 : presc_q + PW'(1));
    cnt_inc  = cnt_q + CW'(1);
    state_d  = state_q;
    cnt_d    = cnt_q;
    secs_d   = secs_q;
    timer_d  = timer_q;
    paused_d = paused_q;

    case (state_q)
      S_IDLE: begin
        if (wrap) begin
          cnt_d = cnt_inc;
          if (cnt_inc == CW'(IDLE_SECS)) state_d = S_MENU;
        end
      end
      S_MENU: begin
        if (|rise) begin
          state_d  = S_PLAY;
          timer_d  = '0;
          secs_d   = '0;
          paused_d = 1'b0;
        end
      end
      S_PLAY: begin
        if (game_over_evt) begin
          state_d = S_OVER;
        end else begin
          if (wrap) begin
            timer_d = bcd_inc(timer_q);
            if (secs_q != '1) secs_d = secs_q + 32'd1;
            if (TIME_LIMIT != 0 && secs_d == TIME_LIMIT) state_d = S_OVER;
          end
          // a pause press loses to any transition out of PLAY
          if (state_d == S_PLAY && PAUSE_EN != 0 && rise[PAUSE_BTN]) paused_d = ~paused_q;
        end
      end
      S_OVER: begin
        if (wrap) begin
          cnt_d = cnt_inc;
          if (cnt_inc == CW'(OVER_SECS)) state_d = S_MENU;
        end
      end
      default: state_d = S_IDLE;
    endcase

    entry = (state_d != state_q);
    if (entry) begin
      presc_d = '0;
      cnt_d   = '0;
    end
    if (state_d != S_PLAY || PAUSE_EN == 0) paused_d = 1'b0;

    state_entry_d = entry;
    start_pulse_d = entry && (state_d == S_PLAY);
    sec_tick_d    = wrap;
    freeze_d      = (state_d == S_OVER) || paused_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      btn_q         <= '0;
      presc_q       <= '0;
      cnt_q         <= '0;
      secs_q        <= '0;
      timer_q       <= '0;
      state_entry_q <= 1'b0;
      start_pulse_q <= 1'b0;
      sec_tick_q    <= 1'b0;
      paused_q      <= 1'b0;
      freeze_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      btn_q         <= btn;
      presc_q       <= presc_d;
      cnt_q         <= cnt_d;
      secs_q        <= secs_d;
      timer_q       <= timer_d;
      state_entry_q <= state_entry_d;
      start_pulse_q <= start_pulse_d;
      sec_tick_q    <= sec_tick_d;
      paused_q      <= paused_d;
      freeze_q      <= freeze_d;
    end
  end

  assign state       = state_q;
  assign state_entry = state_entry_q;
  assign start_pulse = start_pulse_q;
  assign timer_bcd   = timer_q;
  assign sec_tick    = sec_tick_q;
  assign paused      = paused_q;
  assign freeze      = freeze_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Bench for game_state_ctrl: two instances (no limit / 5 s limit) share random
// inputs; a seconds-level reference model feeds per-instance expectation queues.
module tb_game_state_ctrl;
  localparam int TD = 10;
  localparam int IS = 1;
  localparam int OS = 2;
  localparam int ND = 2;
  localparam int NB = 3;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_MENU = 2'b01;
  localparam logic [1:0] ST_PLAY = 2'b11;
  localparam logic [1:0] ST_OVER = 2'b10;

  typedef struct packed {
    logic       entry;
    logic       tick;
    logic [1:0] state;
    logic       start;
    logic [7:0] timer;
    logic       paused;
    logic       freeze;
  } ev_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          go;
  logic [NB-1:0] btn;

  logic [1:0] st0, st1;
  logic       se0, se1, sp0, sp1, tk0, tk1, pz0, pz1, fz0, fz1;
  logic [7:0] tm0, tm1;
  ev_t        a0, a1;

  int total = 0;
  int bad   = 0;

  ev_t q0[$];
  ev_t q1[$];

  logic [1:0] m_st[2];
  int         m_ph[2];
  int         m_secs[2];
  int         m_cnt[2];
  logic       m_pz[2];
  logic [2:0] m_prev[2];
  int         lim[2] = '{0, 5};

  game_state_ctrl #(.TICK_DIV(TD), .NUM_BTN(NB), .IDLE_SECS(IS), .OVER_SECS(OS),
                    .TIMER_DIGITS(ND), .PAUSE_EN(1), .PAUSE_BTN(0), .TIME_LIMIT(0)) dut0 (
    .clk(clk), .reset(reset), .btn(btn), .game_over_evt(go),
    .state(st0), .state_entry(se0), .start_pulse(sp0), .timer_bcd(tm0),
    .sec_tick(tk0), .paused(pz0), .freeze(fz0));

  game_state_ctrl #(.TICK_DIV(TD), .NUM_BTN(NB), .IDLE_SECS(IS), .OVER_SECS(OS),
                    .TIMER_DIGITS(ND), .PAUSE_EN(1), .PAUSE_BTN(0), .TIME_LIMIT(5)) dut1 (
    .clk(clk), .reset(reset), .btn(btn), .game_over_evt(go),
    .state(st1), .state_entry(se1), .start_pulse(sp1), .timer_bcd(tm1),
    .sec_tick(tk1), .paused(pz1), .freeze(fz1));

  assign a0 = {se0, tk0, st0, sp0, tm0, pz0, fz0};
  assign a1 = {se1, tk1, st1, sp1, tm1, pz1, fz1};

  always #5 clk = ~clk;

  function automatic logic [7:0] to_bcd(input int s);
    int         mx;
    int         v;
    logic [7:0] r;
    mx = 1;
    for (int i = 0; i < ND; i++) mx = mx * 10;
    v = (s > mx - 1) ? mx - 1 : s;
    r = '0;
    for (int i = 0; i < ND; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_st[k] = ST_IDLE; m_ph[k] = 0; m_secs[k] = 0; m_cnt[k] = 0;
      m_pz[k] = 1'b0; m_prev[k] = '0;
    end
    q0.delete();
    q1.delete();
  endtask

  // One clock of game rules, written in whole seconds and cycle phases.
  task automatic model_step(input int k);
    logic [2:0] rise;
    logic       tick, old_pz, entry;
    logic [1:0] nxt;
    ev_t        e;
    rise      = btn & ~m_prev[k];
    m_prev[k] = btn;
    tick      = !m_pz[k] && (m_ph[k] == TD - 1);
    if (!m_pz[k]) m_ph[k] = (m_ph[k] + 1) % TD;
    old_pz = m_pz[k];
    nxt    = m_st[k];
    if (m_st[k] == ST_IDLE) begin
      if (tick) begin m_cnt[k]++; if (m_cnt[k] == IS) nxt = ST_MENU; end
    end else if (m_st[k] == ST_MENU) begin
      if (rise != 0) begin nxt = ST_PLAY; m_secs[k] = 0; m_pz[k] = 1'b0; end
    end else if (m_st[k] == ST_PLAY) begin
      if (go) nxt = ST_OVER;
      else begin
        if (tick) begin
          m_secs[k]++;
          if (lim[k] != 0 && m_secs[k] == lim[k]) nxt = ST_OVER;
        end
        if (nxt == ST_PLAY && rise[0]) m_pz[k] = !m_pz[k];
      end
    end else begin
      if (tick) begin m_cnt[k]++; if (m_cnt[k] == OS) nxt = ST_MENU; end
    end
    entry = (nxt != m_st[k]);
    if (entry) begin
      m_ph[k] = 0; m_cnt[k] = 0;
      if (nxt == ST_OVER) m_pz[k] = 1'b0;
    end
    m_st[k] = nxt;
    if (entry || tick || (m_pz[k] != old_pz)) begin
      e.entry  = entry;
      e.tick   = tick;
      e.state  = nxt;
      e.start  = entry && (nxt == ST_PLAY);
      e.timer  = to_bcd(m_secs[k]);
      e.paused = m_pz[k];
      e.freeze = (nxt == ST_OVER) || m_pz[k];
      if (k == 0) q0.push_back(e); else q1.push_back(e);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      if (reset) model_reset();
      else begin
        model_step(0);
        model_step(1);
      end
    end
  end

  task automatic check_ev(input int k, input ev_t act);
    ev_t e;
    int  n;
    n = (k == 0) ? q0.size() : q1.size();
    total++;
    if (n == 0) begin
      bad++;
      $display("FAIL dut%0d unexpected_event got entry=%b tick=%b st=%b start=%b timer=%h pz=%b frz=%b want none",
               k, act.entry, act.tick, act.state, act.start, act.timer, act.paused, act.freeze);
    end else begin
      if (k == 0) e = q0.pop_front(); else e = q1.pop_front();
      if (act !== e) begin
        bad++;
        $display("FAIL dut%0d event got entry=%b tick=%b st=%b start=%b timer=%h pz=%b frz=%b want entry=%b tick=%b st=%b start=%b timer=%h pz=%b frz=%b",
                 k, act.entry, act.tick, act.state, act.start, act.timer, act.paused, act.freeze,
                 e.entry, e.tick, e.state, e.start, e.timer, e.paused, e.freeze);
      end
    end
  endtask

  // Monitor: an output event is a state entry, a second tick or a pause change.
  initial begin
    logic pzp0, pzp1;
    pzp0 = 1'b0;
    pzp1 = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        pzp0 = 1'b0;
        pzp1 = 1'b0;
      end else begin
        if (a0.entry || a0.tick || (a0.paused != pzp0)) check_ev(0, a0);
        if (a1.entry || a1.tick || (a1.paused != pzp1)) check_ev(1, a1);
        pzp0 = a0.paused;
        pzp1 = a1.paused;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_zero(input string name);
    total++;
    if (a0 !== '0) begin
      bad++;
      $display("FAIL %s dut0 outputs got %h want 0", name, a0);
    end
    total++;
    if (a1 !== '0) begin
      bad++;
      $display("FAIL %s dut1 outputs got %h want 0", name, a1);
    end
  endtask

  task automatic check_drained(input string name);
    #2;
    total++;
    if (q0.size() != 0) begin
      bad++;
      $display("FAIL %s dut0 pending got %0d want 0", name, q0.size());
    end
    total++;
    if (q1.size() != 0) begin
      bad++;
      $display("FAIL %s dut1 pending got %0d want 0", name, q1.size());
    end
  endtask

  task automatic wait_menu0(input int budget);
    int n;
    n = 0;
    while (m_st[0] != ST_MENU && n < budget) begin step(1); n++; end
    total++;
    if (m_st[0] != ST_MENU) begin
      bad++;
      $display("FAIL wait_menu timeout got state=%b want %b", m_st[0], ST_MENU);
    end
  endtask

  task automatic reach_play0();
    int n;
    n = 0;
    while (m_st[0] != ST_PLAY && n < 300) begin
      btn = '0; step(1);
      btn = 3'b100; step(1);
      n++;
    end
    btn = '0;
    total++;
    if (m_st[0] != ST_PLAY) begin
      bad++;
      $display("FAIL reach_play timeout got state=%b want %b", m_st[0], ST_PLAY);
    end
  endtask

  initial begin
    reset = 1'b1;
    btn   = 3'b010;
    go    = 1'b0;
    step(3);
    check_zero("reset_state");
    reset = 1'b0;

    // held button through MENU entry, then release and press to start
    wait_menu0(100);
    step(20);
    btn = '0;      step(1);
    btn = 3'b010;  step(1);
    btn = '0;      step(125);

    // pause, hold, resume, then long run to saturate the timer
    btn = 3'b001;  step(1);
    btn = '0;      step(50);
    btn = 3'b001;  step(1);
    btn = '0;      step(1100);

    // pause, then game over together with a pause press
    btn = 3'b001;  step(1);
    btn = '0;      step(50);
    btn = 3'b001;  go = 1'b1; step(1);
    btn = '0;      go = 1'b0; step(30);

    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) btn = 3'($urandom_range(0, 7));
      go = ($urandom_range(0, 149) == 0);
      step(1);
    end
    btn = '0;
    go  = 1'b0;

    // asynchronous reset in the middle of PLAY
    reach_play0();
    step(37);
    check_drained("before_async_reset");
    total++;
    if (st0 !== ST_PLAY) begin
      bad++;
      $display("FAIL pre_reset_state got %b want %b", st0, ST_PLAY);
    end
    #1 reset = 1'b1;
    #1 check_zero("async_reset");
    step(2);
    reset = 1'b0;

    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 5) == 0) btn = 3'($urandom_range(0, 7));
      go = ($urandom_range(0, 99) == 0);
      step(1);
    end
    btn = '0;
    go  = 1'b0;
    step(5);
    check_drained("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
